// File: rtl/uart_frame_parser.sv
// Parses {HDR_BYTE, LEN} + LEN payload words + XOR checksum from a registered-read RX FIFO.
// One pop in flight at most; payload held on out_data until out_ready; idle timeout aborts frames.
module uart_frame_parser #(
  parameter logic [7:0] HDR_BYTE = 8'hA5,
  parameter int         MAX_LEN  = 8,
  parameter int         TIMEOUT  = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_rd_data,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] ok_cnt,
  output logic [15:0] bad_cnt
);

  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

  state_t          state;
  logic            pend;
  logic [15:0]     acc;
  logic [3:0]      rem;
  logic [IW-1:0]   idle_cnt;
  logic            timeout_hit;
  logic [7:0]      hdr_len;

  assign hdr_len = fifo_rd_data[7:0];

  // A pop is only issued when the output slot will be free by the time its data returns.
  assign fifo_rd_en = !rst && !fifo_empty && !pend && (!out_valid || out_ready);

  assign timeout_hit = (state != HUNT) && !pend && !fifo_rd_en &&
                       (idle_cnt == IW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      pend       <= 1'b0;
      acc        <= '0;
      rem        <= '0;
      idle_cnt   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
      ok_cnt     <= '0;
      bad_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      pend       <= fifo_rd_en;

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      if (fifo_rd_en || state == HUNT)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;

      if (pend) begin
        case (state)
          HUNT: begin
            if (fifo_rd_data[15:8] == HDR_BYTE) begin
              if (hdr_len == 8'd0 || hdr_len > 8'(MAX_LEN)) begin
                frame_err <= 1'b1;
                err_code  <= 2'b01;
                if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
              end else begin
                rem   <= hdr_len[3:0];
                acc   <= '0;
                state <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            out_data  <= fifo_rd_data;
            out_valid <= 1'b1;
            out_last  <= (rem == 4'd1);
            acc       <= acc ^ fifo_rd_data;
            rem       <= rem - 4'd1;
            if (rem == 4'd1) state <= CHECK;
          end
          CHECK: begin
            if (fifo_rd_data == acc) begin
              frame_done <= 1'b1;
              if (ok_cnt != 16'hFFFF) ok_cnt <= ok_cnt + 16'd1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'b10;
              if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
            end
            state <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end else if (timeout_hit) begin
        // A word already sitting in the output register still drains normally.
        frame_err <= 1'b1;
        err_code  <= 2'b11;
        if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
        state     <= HUNT;
        idle_cnt  <= '0;
      end
    end
  end

endmodule
